clock_gen: RTL
==============

// Module: clock_gen
// PURPOSE
//  Programmable system clock generator for the 6502 core: divides clk_in by a runtime-loadable
//  divisor into a 50%-nominal-duty clk_out, with single-cycle phi_rise/phi_fall strobes in the
//  clk_in domain. Supports free-run, halt and single-step modes for board-level debug.
//  Sits between the board oscillator and the CPU/bus clock enables.
// PARAMETERS
//  CNT_W        28         counter/divisor width
//  DEFAULT_DIV  2_000_000  divisor after reset; must satisfy 2 <= DEFAULT_DIV < 2**CNT_W
//  STEP_SYNC    2          synchroniser depth for step_req (>=2)
// PORTS
//  clk_in      in   1      board clock; all logic on its rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  div_in      in   CNT_W  new divisor value
//  div_load    in   1      1-cycle strobe: capture div_in into the pending register
//  mode        in   2      00 RUN, 01 HALT, 10 STEP, 11 reserved (treated as HALT)
//  step_req    in   1      asynchronous step button (already debounced)
//  clk_out     out  1      divided clock (registered)
//  phi_rise    out  1      high for the one clk_in cycle in which clk_out first reads 1
//  phi_fall    out  1      high for the one clk_in cycle in which clk_out first reads 0
//  running     out  1      1 while a period is in progress (state != PARK)
//  div_active  out  CNT_W  divisor currently in effect
// BEHAVIOUR
//  - Reset (async, any time): state=PARK, counter=DEFAULT_DIV-1, div_active=pending=DEFAULT_DIV,
//    clk_out=0, phi_rise=0, phi_fall=0, running=0, step synchroniser cleared.
//  - Counter runs 0..D-1 with D=div_active. Registered: clk_out <= (next_cnt < D/2), integer
//    divide; odd D gives floor(D/2) high cycles, ceil(D/2) low. phi_rise <= (next_cnt==0 && advancing);
//    phi_fall <= (next_cnt==D/2 && advancing).
//  - div_load: pending <= max(div_in, 2) (values 0 and 1 clamp to 2). Pending copies to div_active
//    only at a period launch (counter D-1 -> 0); never mid-period. Last load before launch wins.
//  - FSM {PARK, RUN, STEP}:
//    PARK: counter held at D-1, clk_out=0. mode RUN -> launch next edge, state RUN.
//      mode STEP and a synchronised step_req rising edge -> launch, state STEP. Otherwise stay.
//    RUN: at counter==D-1: if mode==RUN wrap to 0 (launch), else -> PARK holding D-1.
//    STEP: runs exactly one period; at counter==D-1 -> PARK. step edges during STEP are dropped.
//  - Mode changes take effect only at period end; a period is never truncated or stretched.
//  - step_req: STEP_SYNC-flop synchroniser + rising-edge detect; ignored unless state==PARK and
//    mode==STEP. First phi_rise occurs STEP_SYNC+1 clk_in edges after step_req is first sampled 1.
//  - running registered: 1 from launch cycle through counter==D-1 of last period.
// TESTING  (DEFAULT_DIV=4, STEP_SYNC=2 unless stated)
//  1 Release rst_n with mode=RUN -> clk_out 1,1,0,0 repeating from first edge; phi_rise every
//    4 cycles coincident with clk_out rise; phi_fall 2 cycles later; running=1.
//  2 div_load div_in=5 at counter=1 -> current period stays 4 cycles; next period 1,1,0,0,0;
//    div_active reads 5 from that launch cycle.
//  3 div_load div_in=0 -> div_active=2 at next launch; clk_out toggles 1,0 every clk_in cycle.
//  4 RUN, switch mode=HALT at counter=0 -> period completes (1,1,0,0), then clk_out held 0,
//    running=0, no strobes; mode=RUN again -> phi_rise on next edge.
//  5 mode=STEP parked; step_req high 3 cycles -> exactly one period 1,1,0,0 with one phi_rise/
//    phi_fall, then PARK; second step_req pulse during that period -> no extra period.
//  6 Assert rst_n low mid-high phase -> clk_out, strobes, running 0 immediately; after release
//    in RUN, phi_rise on first edge and div_active back to DEFAULT_DIV.

Source files
------------

// File: rtl/clock_gen.sv
// -----------------------------------------------------------------------------
// clock_gen
//   Programmable system clock generator for the 6502 core. Divides clk_in by a
//   runtime-loadable divisor D into clk_out: floor(D/2) high cycles, then
//   ceil(D/2) low cycles. phi_rise/phi_fall are single-cycle strobes in the
//   clk_in domain that align with the clk_out edges. It supports free-run, halt
//   and single-step modes for board-level debug.
//
// Ports
//   clk_in      board clock; all logic is on its rising edge
//   rst_n       asynchronous, active-low reset
//   div_in      new divisor value (CNT_W bits)
//   div_load    1-cycle strobe: capture max(div_in, 2) into the pending divisor
//   mode        00 RUN, 01 HALT, 10 STEP, 11 treated as HALT
//   step_req    asynchronous, debounced step button
//   clk_out     divided clock (registered)
//   phi_rise    high in the cycle where clk_out first reads 1
//   phi_fall    high in the cycle where clk_out first reads 0
//   running     high while a period is in progress
//   div_active  divisor currently in effect
// -----------------------------------------------------------------------------
module clock_gen #(
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 2_000_000,
    parameter int STEP_SYNC   = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic             clk_out,
    output logic             phi_rise,
    output logic             phi_fall,
    output logic             running,
    output logic [CNT_W-1:0] div_active
);
    localparam logic [CNT_W-1:0] DEF_D     = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_D     = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [1:0]       MODE_RUN  = 2'b00;
    localparam logic [1:0]       MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [CNT_W-1:0]     pending_reg;
    logic [CNT_W-1:0]     last_cnt;      // D-1 for the divisor in effect now
    logic [CNT_W-1:0]     div_next;      // divisor in effect after this edge
    logic [CNT_W-1:0]     half_next;     // floor(div_next/2): first low count
    logic                 launch;        // counter goes D-1 -> 0 this edge
    logic                 advancing;     // counter moves this edge
    logic                 clk_out_next, phi_rise_next, phi_fall_next;

    // step_req synchroniser chain plus one extra flop for rising-edge detect
    logic [STEP_SYNC-1:0] sync_reg;
    logic [STEP_SYNC-1:0] sync_d;
    logic                 step_prev_reg;
    logic                 step_edge;

    genvar gi;
    generate
        for (gi = 0; gi < STEP_SYNC; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign sync_d[gi] = step_req;
            end else begin : g_tail
                assign sync_d[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign step_edge = sync_reg[STEP_SYNC-1] & ~step_prev_reg;
    assign last_cnt  = div_active - ONE;

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= PARK;
            cnt_reg       <= DEF_D - ONE;
            pending_reg   <= DEF_D;
            div_active    <= DEF_D;
            sync_reg      <= '0;
            step_prev_reg <= 1'b0;
            clk_out       <= 1'b0;
            phi_rise      <= 1'b0;
            phi_fall      <= 1'b0;
            running       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sync_reg      <= sync_d;
            step_prev_reg <= sync_reg[STEP_SYNC-1];
            if (div_load) begin
                pending_reg <= (div_in < MIN_D) ? MIN_D : div_in;
            end
            // The divisor only changes at a period boundary, never mid-period.
            if (launch) begin
                div_active <= pending_reg;
            end
            clk_out  <= clk_out_next;
            phi_rise <= phi_rise_next;
            phi_fall <= phi_fall_next;
            running  <= (state_next != PARK);
        end
    end

    // Next-state logic: mode is only consulted in PARK or at counter == D-1,
    // so a period is never truncated or stretched.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        launch     = 1'b0;
        case (state_reg)
            PARK: begin
                if (mode == MODE_RUN) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end else if (mode == MODE_STEP && step_edge) begin
                    launch     = 1'b1;
                    state_next = STEP;
                end
            end
            RUN: begin
                if (cnt_reg == last_cnt) begin
                    if (mode == MODE_RUN) begin
                        launch = 1'b1;
                    end else begin
                        state_next = PARK;
                    end
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            STEP: begin
                if (cnt_reg == last_cnt) begin
                    state_next = PARK;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            default: state_next = PARK;
        endcase
        if (launch) begin
            cnt_next = '0;
        end
    end

    // Output logic. Strobes are gated by advancing so that a held counter
    // (PARK, or the park transition with D=2 where D-1 == D/2) never fires one.
    always_comb begin
        advancing     = launch | ((state_reg != PARK) && (cnt_reg != last_cnt));
        div_next      = launch ? pending_reg : div_active;
        half_next     = div_next >> 1;
        clk_out_next  = (cnt_next < half_next);
        phi_rise_next = advancing && (cnt_next == '0);
        phi_fall_next = advancing && (cnt_next == half_next);
    end

endmodule
